// File: rtl/display_pkg.sv
// Shared types and constants for the CPU output display: converter states,
// active-low seven-segment patterns and the digit count.
package display_pkg;
  localparam int DIGITS = 3;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_e;

  // Patterns are {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/cpu_out_display_if.sv
// Bundle between the CPU output register (master) and the display block (slave).
interface cpu_out_display_if;
  logic [7:0]  valueIn;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;

  modport master (output valueIn, input seg, an, bcd, busy);
  modport slave  (input valueIn, output seg, an, bcd, busy);
endinterface

// File: rtl/cpu_out_display_bin_to_bcd_seq.sv
// Sequential double-dabble: one bit per cycle, digits committed only when the
// whole conversion is done so downstream never sees partial results.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      valueIn,
  input  logic                       start,
  output logic [DIGITS-1:0][3:0]     bcd,
  output logic                       busy
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  conv_state_e                   state;
  logic [DATA_WIDTH-1:0]         shift_q;
  logic [DIGITS-1:0][3:0]        scratch, adj;
  logic [CW-1:0]                 bit_cnt;
  logic [DIGITS*4+DATA_WIDTH-1:0] sh_nxt;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      if (scratch[i] >= 4'd5) adj[i] = scratch[i] + 4'd3;
  end

  assign sh_nxt = {adj, shift_q} << 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift_q <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shift_q <= valueIn;
          scratch <= '0;
          bit_cnt <= '0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          {scratch, shift_q} <= sh_nxt;
          bit_cnt            <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd   <= scratch;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/cpu_out_display.sv
// CPU output to 3-digit multiplexed seven-segment display: change detect, BCD
// convert, scan. Optional `LEADING_ZERO_BLANK_EN blanks leading zero digits.
module cpu_out_display
  import display_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic             clk,
  input  logic             reset,
  cpu_out_display_if.slave bus
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DATA_WIDTH-1:0]  last_value;
  logic                   start, busy;
  logic [DIGITS-1:0][3:0] bcd;
  logic [PW-1:0]          presc;
  logic [1:0]             scan_idx, scan_nxt;
  logic [6:0]             seg_nxt;
  logic [2:0]             an_nxt;
  logic [3:0]             digit;

  // Only compare while idle; changes during a conversion wait for the next idle cycle.
  assign start = !busy && (bus.valueIn != last_value);

  bin_to_bcd_seq #(.DATA_WIDTH(DATA_WIDTH)) u_conv (
    .clk     (clk),
    .reset   (reset),
    .valueIn (bus.valueIn),
    .start   (start),
    .bcd     (bcd),
    .busy    (busy)
  );

  assign bus.bcd  = bcd;
  assign bus.busy = busy;

  always_comb begin
    scan_nxt = scan_idx;
    if (presc == PW'(SCAN_DIV - 1)) scan_nxt = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    case (scan_nxt)
      2'd1:    digit = bcd[1];
      2'd2:    digit = bcd[2];
      default: digit = bcd[0];
    endcase
    seg_nxt = seg_encode(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (scan_nxt == 2'd2 && bcd[2] == 4'd0) seg_nxt = SEG_BLANK;
    if (scan_nxt == 2'd1 && bcd[2] == 4'd0 && bcd[1] == 4'd0) seg_nxt = SEG_BLANK;
`endif
    an_nxt = ~(3'b001 << scan_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_value <= '0;
      presc      <= '0;
      scan_idx   <= '0;
      bus.an     <= 3'b110;
      bus.seg    <= SEG_0;
    end else begin
      // lastValue is only consulted while idle, so latching at start is equivalent to at commit.
      if (start) last_value <= bus.valueIn;
      presc    <= (presc == PW'(SCAN_DIV - 1)) ? '0 : presc + 1'b1;
      scan_idx <= scan_nxt;
      bus.an   <= an_nxt;
      bus.seg  <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_cpu_out_display.sv
// Bench for cpu_out_display: vector table, hand-written corner sequences and
// random input changes checked every cycle against a timeline model.
module tb_cpu_out_display;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  bit   saw_busy = 0;
  bit   watch_busy = 0;

  cpu_out_display_if bus();

  cpu_out_display #(.DATA_WIDTH(8), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ENC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx);
    int d = (idx == 0) ? int'(b[3:0]) : (idx == 1) ? int'(b[7:4]) : int'(b[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2 && b[11:8] == 0) return 7'b1111111;
    if (idx == 1 && b[11:4] == 0) return 7'b1111111;
`endif
    return ENC[d];
  endfunction

  // Timeline model: a sampled change takes 9 edges to commit; scan position is edges/SD mod 3.
  logic [11:0] m_bcd;
  logic        m_busy;
  logic [7:0]  m_last, m_val;
  logic [6:0]  m_seg;
  logic [2:0]  m_an;
  int          m_left, m_n;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bcd = 0; m_busy = 0; m_last = 0; m_val = 0; m_left = 0; m_n = 0;
      m_an = 3'b110; m_seg = ENC[0];
    end else begin
      logic [11:0] prev;
      int idx;
      prev = m_bcd;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_bcd = to_bcd(int'(m_val)); m_busy = 0; end
      end else if (bus.valueIn != m_last) begin
        m_val = bus.valueIn; m_last = bus.valueIn; m_busy = 1; m_left = 9;
      end
      m_n++;
      idx = (m_n / SD) % 3;
      m_an = ~(3'b001 << idx);
      m_seg = exp_seg(prev, idx);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("model_seg", bus.seg, m_seg);
      check("model_an", bus.an, m_an);
      check("model_bcd", bus.bcd, m_bcd);
      check("model_busy", bus.busy, m_busy);
      check("an_onehot", $countones(~bus.an), 1);
      if (watch_busy && bus.busy) saw_busy = 1;
    end
  end

  task automatic check_digit(input int idx, input logic [6:0] exp, input string nm);
    bit found = 0;
    logic [2:0] want = ~(3'b001 << idx);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.an == want) found = 1;
    end
    check({nm, "_an_found"}, found, 1);
    check(nm, bus.seg, exp);
  endtask

  typedef struct {
    logic [7:0]  val;
    logic [11:0] exp_bcd;
  } vec_t;

  initial begin
    vec_t vecs [9];
    int cnt;
    vecs = '{'{8'd255, 12'h255}, '{8'd100, 12'h100}, '{8'd7, 12'h007},
             '{8'd0, 12'h000}, '{8'd99, 12'h099}, '{8'd10, 12'h010},
             '{8'd128, 12'h128}, '{8'd1, 12'h001}, '{8'd250, 12'h250}};
    bus.valueIn = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd", bus.bcd, 12'h000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_an", bus.an, 3'b110);
    check("rst_seg", bus.seg, 7'b1000000);
    reset = 1'b1;

    // Zero input after release: nothing to convert.
    repeat (5) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_bcd", bus.bcd, 12'h000);

    // 0 -> 255: busy for exactly 9 cycles.
    bus.valueIn = 8'd255;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    check("busy_cycles", cnt, 9);
    check("bcd_255", bus.bcd, 12'h255);
    check_digit(0, 7'b0010010, "d255_units");
    check_digit(1, 7'b0010010, "d255_tens");
    check_digit(2, 7'b0100100, "d255_hund");

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.valueIn = vecs[i].val;
      repeat (12) @(negedge clk);
      check($sformatf("vec_bcd_%0d", vecs[i].val), bus.bcd, vecs[i].exp_bcd);
      if (vecs[i].val == 8'd100) check_digit(1, 7'b1000000, "d100_tens");
      if (vecs[i].val == 8'd7) begin
`ifdef LEADING_ZERO_BLANK_EN
        check_digit(2, 7'b1111111, "d7_hund");
        check_digit(1, 7'b1111111, "d7_tens");
`else
        check_digit(2, 7'b1000000, "d7_hund");
        check_digit(1, 7'b1000000, "d7_tens");
`endif
        check_digit(0, 7'b1111000, "d7_units");
      end
    end

    // 200 then 37 mid-conversion: first commit is 200, then 37 restarts immediately.
    @(negedge clk);
    bus.valueIn = 8'd200;
    repeat (4) @(negedge clk);
    bus.valueIn = 8'd37;
    repeat (6) @(negedge clk);
    check("chg_first_bcd", bus.bcd, 12'h200);
    check("chg_first_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("chg_restart_busy", bus.busy, 1'b1);
    repeat (9) @(negedge clk);
    check("chg_final_bcd", bus.bcd, 12'h037);

    // Reset mid-conversion, then reconvert the held value.
    @(negedge clk);
    bus.valueIn = 8'd199;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_bcd", bus.bcd, 12'h000);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_an", bus.an, 3'b110);
    check("midrst_seg", bus.seg, 7'b1000000);
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(negedge clk);
    check("rerun_pre_bcd", bus.bcd, 12'h000);
    check("rerun_pre_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("rerun_bcd", bus.bcd, 12'h199);

    // Held input: no further conversions; anode scan checked each cycle.
    @(negedge clk);
    watch_busy = 1;
    repeat (1000) @(negedge clk);
    watch_busy = 0;
    check("hold_no_busy", saw_busy, 1'b0);

    // Random value changes against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bus.valueIn = 8'($urandom);
    end
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/cpu_out_display.md
# cpu_out_display

Drives a 3-digit multiplexed seven-segment display from the CPU core's 8-bit output register (`cpuOut`). It sits directly downstream of the CPU core. It detects a change in the value and converts it to BCD with a sequential double-dabble engine (one bit per cycle). It then time-multiplexes the three decimal digits onto shared, active-low segment and anode lines.

## Interface
- `DATA_WIDTH`, 8: width of the input value; fixed at 8, which implies 3 decimal digits.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit; must be ≥2.

- `clk` in 1: single system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `valueIn` in 8: unsigned value from `cpuOut`.
- `seg` out 7: segment lines {g,f,e,d,c,b,a}, active-low.
- `an` out 3: digit anodes, active-low; bit 0 is units, bit 2 is hundreds.
- `bcd` out 12: committed digits {hundreds, tens, units}.
- `busy` out 1: high while a conversion is in progress.

## Operation
- Reset values:
  - `bcd`=0, `busy`=0, internal `lastValue`=0.
  - Scan index=0 and prescaler=0.
  - `an`=3'b110 and `seg`=7'b1000000 ("0" on units).
- Converter FSM has three states: IDLE, CONV, COMMIT.
  - IDLE: if `valueIn != lastValue`, capture `valueIn` into the shift register, clear the 12-bit BCD scratch, set bitCount=0, go to CONV, and set `busy`=1.
  - CONV: each cycle, add 3 to every scratch nibble ≥5. Then left-shift {scratch, shift} by one. Increment bitCount. After the 8th shift, go to COMMIT.
  - COMMIT: `bcd` ← scratch, `lastValue` ← captured value, `busy`=0, go to IDLE.
- Changes on `valueIn` during CONV or COMMIT are ignored. They are re-evaluated on the first IDLE cycle, so a single conversion always completes.
- The displayed digits never show partial conversion results.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances 0→1→2→0.
  - `an` is one-hot-low for the current index; `seg` is the encoding of the selected `bcd` nibble.
  - `seg` and `an` are registered and change on the same edge.
- Encoding for 0–9 uses the standard active-low patterns. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- The change is sampled at edge E0. `busy` rises at E0.
- CONV occupies edges E1–E8; COMMIT is at E9. `bcd` is updated and `busy` falls at E9.
- Latency from sampling to committed digits is 9 cycles.
- The new digits appear on `seg` at the next scan register update after E9, i.e. at most 1 cycle later when that digit is active.
- A back-to-back change seen at the IDLE cycle after E9 starts a new conversion immediately, giving a minimum period of 10 cycles per conversion.
- Asserting reset mid-conversion:
  - aborts the conversion immediately;
  - forces all reset values;
  - `lastValue`=0, so a nonzero input reconverts after release.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined:
    - hundreds is blanked (`seg`=7'b1111111) when it is 0;
    - tens is blanked when hundreds and tens are both 0;
    - units is never blanked.
    - `an` still scans normally.
  - Undefined: all three digits are always shown, so 7 is shown as "007".
  - Reset display output is identical in both cases.

## Structure
- Shared package `display_pkg`:
  - converter state enum (IDLE/CONV/COMMIT);
  - 7-bit segment constants for 0–9 and SEG_BLANK;
  - DIGITS=3 constant.
- Sub-module `bin_to_bcd_seq` holds the converter FSM, shift/scratch registers and bitCount. Its ports are `valueIn`, `start`, `bcd`, `busy`.
- The top level holds the change detector, `lastValue`, prescaler, scan index and segment mux/encoder.

## Test plan
- Reset release with `valueIn`=0 → no conversion (`busy` stays 0); units shows 1000000; `bcd`=12'h000.
- `valueIn`: 0→255 → `busy` high for 9 cycles; `bcd`=12'h255 at E9. With `SCAN_DIV`=4, anodes cycle 110→101→011 every 4 cycles, showing 5, 5, 2.
- `valueIn`=100 with `LEADING_ZERO_BLANK_EN` → `bcd`=12'h100; tens shows "0" (not blanked). `valueIn`=7 → hundreds and tens show 1111111; units shows 1111000.
- Change 200→37 at E3 of an in-progress conversion → the first commit gives 12'h200; the second conversion starts on the next IDLE cycle; final `bcd`=12'h037.
- Reset asserted at E5 of converting 199 → immediate reset values. After release with `valueIn`=199, `bcd`=12'h199 9 cycles after the first sampling edge.
- Hold `valueIn` constant for 1000 cycles → `busy` never asserts after the first conversion; the scan index wraps 2→0 without glitching `an` (never two digits low at once).
